// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory-port arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, ISSUE, RESP)
//   mem_size_t   : access size encoding (B/H/W/D = 0..3)
//   xfer_kind_t  : which requester owns the current transaction
//   ADDR_W       : default physical address width
//   LANE_MASK_*  : byte-enable patterns for each size, before lane shifting
package mem_arbiter_pkg;

    localparam int ADDR_W = 56;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } mem_size_t;

    typedef enum logic [1:0] {
        KIND_FETCH = 2'd0,
        KIND_LOAD  = 2'd1,
        KIND_STORE = 2'd2
    } xfer_kind_t;

    // last_grant encoding
    localparam logic GRANT_DATA  = 1'b0;
    localparam logic GRANT_FETCH = 1'b1;

    localparam logic [7:0] LANE_MASK_B = 8'h01;
    localparam logic [7:0] LANE_MASK_H = 8'h03;
    localparam logic [7:0] LANE_MASK_W = 8'h0F;
    localparam logic [7:0] LANE_MASK_D = 8'hFF;

    function automatic logic [7:0] lane_mask(input mem_size_t size);
        case (size)
            SIZE_B:  return LANE_MASK_B;
            SIZE_H:  return LANE_MASK_H;
            SIZE_W:  return LANE_MASK_W;
            default: return LANE_MASK_D;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 64-bit memory word.
//   size, addr_lo, is_unsigned : registered request fields
//   rdata     : raw read word from memory
//   wdata_in  : right-justified store data
//   instr     : 32-bit instruction lane selected by addr_lo[2]
//   rdata_ext : extracted load value, sign- or zero-extended to 64 bits
//   wdata     : store data shifted into its lane
//   byte_en   : store byte enables shifted into the lane
// Low address bits below the access size are dropped, so an unaligned
// address selects the naturally aligned lane that contains it.
module mem_lane_align
    import mem_arbiter_pkg::*;
(
    input  mem_size_t   size,
    input  logic [2:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [63:0] rdata,
    input  logic [63:0] wdata_in,
    output logic [31:0] instr,
    output logic [63:0] rdata_ext,
    output logic [63:0] wdata,
    output logic [7:0]  byte_en
);

    logic [2:0]  byte_off;
    logic [63:0] shifted;
    logic        sign_en;

    always_comb begin
        byte_off = 3'd0;
        case (size)
            SIZE_B:  byte_off = addr_lo;
            SIZE_H:  byte_off = {addr_lo[2:1], 1'b0};
            SIZE_W:  byte_off = {addr_lo[2], 2'b00};
            default: byte_off = 3'd0;
        endcase
    end

    assign shifted = rdata >> {byte_off, 3'b000};
    assign sign_en = ~is_unsigned;

    always_comb begin
        rdata_ext = rdata;
        case (size)
            SIZE_B:  rdata_ext = {{56{shifted[7]  & sign_en}}, shifted[7:0]};
            SIZE_H:  rdata_ext = {{48{shifted[15] & sign_en}}, shifted[15:0]};
            SIZE_W:  rdata_ext = {{32{shifted[31] & sign_en}}, shifted[31:0]};
            default: rdata_ext = rdata;
        endcase
    end

    assign instr   = addr_lo[2] ? rdata[63:32] : rdata[31:0];
    assign wdata   = wdata_in << {byte_off, 3'b000};
    assign byte_en = lane_mask(size) << byte_off;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 64-bit memory port between instruction fetch and
// data load/store, one outstanding transaction at a time.
//   phi1, rst            : clock; asynchronous active-high reset
//   instruction_*        : fetch request/response (32-bit instruction)
//   data_*, input_data_* : load request/response (64-bit extended data)
//   output_data_*        : store request/completion
//   misaligned           : pulse alongside a rejected data response
//   mem_*                : memory port (req/we/address/byte_en/wdata, rdata/ack)
// Optional feature: define MEM_ARBITER_ALIGN_CHECK_EN to reject misaligned
// data accesses without touching memory; otherwise misaligned is tied low.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int   ADDR_W          = mem_arbiter_pkg::ADDR_W,
    parameter logic MEM_RESET_GRANT = 1'b0
) (
    input  logic              phi1,
    input  logic              rst,
    input  logic [ADDR_W-1:0] instruction_address,
    input  logic              input_instruction_request,
    output logic [31:0]       input_instruction,
    output logic              input_instruction_valid,
    input  logic [ADDR_W-1:0] data_address,
    input  logic [1:0]        data_size,
    input  logic              input_data_request,
    input  logic              input_data_unsigned,
    output logic [63:0]       input_data,
    output logic              input_data_valid,
    input  logic [63:0]       output_data,
    input  logic              output_data_request,
    output logic              output_data_complete,
    output logic              misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_address,
    output logic [7:0]        mem_byte_en,
    output logic [63:0]       mem_wdata,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack
);

    arb_state_t        state_q, state_d;
    xfer_kind_t        kind_q, kind_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    mem_size_t         size_q, size_d;
    logic              uns_q, uns_d;
    logic [63:0]       wdata_q, wdata_d;
    logic              last_grant_q, last_grant_d;
    logic [31:0]       instr_q, instr_d;
    logic [63:0]       rdata_q, rdata_d;

    logic              data_pending;
    logic              grant_fetch;
    logic [31:0]       instr_lane;
    logic [63:0]       load_lane;
    logic [63:0]       wdata_lane;
    logic [7:0]        be_lane;

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic misaligned_req;

    always_comb begin
        case (mem_size_t'(data_size))
            SIZE_H:  misaligned_req = data_address[0];
            SIZE_W:  misaligned_req = |data_address[1:0];
            SIZE_D:  misaligned_req = |data_address[2:0];
            default: misaligned_req = 1'b0;
        endcase
    end

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end

    assign misaligned = (state_q == RESP) && misalign_q;
`else
    assign misaligned = 1'b0;
`endif

    assign data_pending = input_data_request | output_data_request;

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        addr_d       = addr_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        instr_d      = instr_q;
        rdata_d      = rdata_q;
        grant_fetch  = 1'b0;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            IDLE: begin
                if (input_instruction_request || data_pending) begin
                    // Round-robin: fetch wins a tie only if data had the last grant.
                    grant_fetch = input_instruction_request &&
                                  (!data_pending || last_grant_q == GRANT_DATA);
                    state_d = ISSUE;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
                    misalign_d = 1'b0;
`endif
                    if (grant_fetch) begin
                        kind_d       = KIND_FETCH;
                        addr_d       = instruction_address;
                        size_d       = SIZE_W;
                        uns_d        = 1'b1;
                        last_grant_d = GRANT_FETCH;
                    end else begin
                        // A store collides with a load only on a protocol error;
                        // serve the store first and leave the load pending.
                        kind_d       = output_data_request ? KIND_STORE : KIND_LOAD;
                        addr_d       = data_address;
                        size_d       = mem_size_t'(data_size);
                        uns_d        = input_data_unsigned;
                        wdata_d      = output_data;
                        last_grant_d = GRANT_DATA;
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
                        if (misaligned_req) begin
                            misalign_d = 1'b1;
                            state_d    = RESP;
                            if (!output_data_request) rdata_d = 64'd0;
                        end
`endif
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_d = RESP;
                    if (kind_q == KIND_FETCH)     instr_d = instr_lane;
                    else if (kind_q == KIND_LOAD) rdata_d = load_lane;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge phi1 or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            kind_q       <= KIND_FETCH;
            addr_q       <= '0;
            size_q       <= SIZE_B;
            uns_q        <= 1'b0;
            wdata_q      <= 64'd0;
            last_grant_q <= MEM_RESET_GRANT;
            instr_q      <= 32'd0;
            rdata_q      <= 64'd0;
        end else begin
            state_q      <= state_d;
            kind_q       <= kind_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            instr_q      <= instr_d;
            rdata_q      <= rdata_d;
        end
    end

    mem_lane_align u_lane_align (
        .size        (size_q),
        .addr_lo     (addr_q[2:0]),
        .is_unsigned (uns_q),
        .rdata       (mem_rdata),
        .wdata_in    (wdata_q),
        .instr       (instr_lane),
        .rdata_ext   (load_lane),
        .wdata       (wdata_lane),
        .byte_en     (be_lane)
    );

    // mem_req decodes straight from the state flop so an asynchronous reset
    // drops it immediately.
    assign mem_req     = (state_q == ISSUE);
    assign mem_we      = mem_req && (kind_q == KIND_STORE);
    assign mem_byte_en = mem_we ? be_lane : 8'h00;
    assign mem_wdata   = wdata_lane;
    assign mem_address = {addr_q[ADDR_W-1:3], 3'b000};

    assign input_instruction       = instr_q;
    assign input_data              = rdata_q;
    assign input_instruction_valid = (state_q == RESP) && (kind_q == KIND_FETCH);
    assign input_data_valid        = (state_q == RESP) && (kind_q == KIND_LOAD);
    assign output_data_complete    = (state_q == RESP) && (kind_q == KIND_STORE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int K_FETCH = 0;
    localparam int K_LOAD  = 1;
    localparam int K_STORE = 2;

    logic        phi1 = 1'b0;
    logic        rst;
    logic [55:0] instruction_address;
    logic        input_instruction_request;
    logic [31:0] input_instruction;
    logic        input_instruction_valid;
    logic [55:0] data_address;
    logic [1:0]  data_size;
    logic        input_data_request;
    logic        input_data_unsigned;
    logic [63:0] input_data;
    logic        input_data_valid;
    logic [63:0] output_data;
    logic        output_data_request;
    logic        output_data_complete;
    logic        misaligned;
    logic        mem_req;
    logic        mem_we;
    logic [55:0] mem_address;
    logic [7:0]  mem_byte_en;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    always #5 phi1 = ~phi1;

    mem_arbiter dut (
        .phi1                      (phi1),
        .rst                       (rst),
        .instruction_address       (instruction_address),
        .input_instruction_request (input_instruction_request),
        .input_instruction         (input_instruction),
        .input_instruction_valid   (input_instruction_valid),
        .data_address              (data_address),
        .data_size                 (data_size),
        .input_data_request        (input_data_request),
        .input_data_unsigned       (input_data_unsigned),
        .input_data                (input_data),
        .input_data_valid          (input_data_valid),
        .output_data               (output_data),
        .output_data_request       (output_data_request),
        .output_data_complete      (output_data_complete),
        .misaligned                (misaligned),
        .mem_req                   (mem_req),
        .mem_we                    (mem_we),
        .mem_address               (mem_address),
        .mem_byte_en               (mem_byte_en),
        .mem_wdata                 (mem_wdata),
        .mem_rdata                 (mem_rdata),
        .mem_ack                   (mem_ack)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: last delivered response values (outputs hold them).
    logic [63:0] last_load_exp;
    logic [31:0] last_instr_exp;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge phi1);
        #1;
    endtask

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [2:0] pulses();
        return {input_instruction_valid, input_data_valid, output_data_complete};
    endfunction

    // Lane offset in bytes: address truncated down to a multiple of the size.
    function automatic int lane_off(input logic [2:0] lo, input int size);
        int nbytes = 1 << size;
        return (int'(lo) / nbytes) * nbytes;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] word, input logic [2:0] lo,
                                               input int size, input bit uns);
        int nbytes = 1 << size;
        logic [63:0] keep;
        logic [63:0] v;
        if (nbytes == 8) return word;
        keep = (64'd1 << (8 * nbytes)) - 64'd1;
        v = (word >> (8 * lane_off(lo, size))) & keep;
        if (!uns && v[8 * nbytes - 1]) v = v | ~keep;
        return v;
    endfunction

    task automatic drop_all();
        input_instruction_request = 1'b0;
        input_data_request        = 1'b0;
        output_data_request       = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drop_all();
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;
        step();
        step();
        rst = 1'b0;
        last_load_exp  = 64'd0;
        last_instr_exp = 32'd0;
    endtask

    // Serve the transaction of kind 'kind' using the currently driven request
    // fields; the requester drops its request during RESP.
    task automatic serve(input int kind, input logic [63:0] rdata, input int wait_cyc,
                         input string tag);
        int lat = 0;
        int sz;
        int off;
        logic [63:0] exp_addr;
        logic [63:0] exp_val;
        logic [2:0]  exp_pulse;
        sz = int'(data_size);
        while (mem_req !== 1'b1 && lat < 10) begin
            step();
            lat++;
        end
        check({tag, " req_latency"}, 64'(lat), 64'd1);
        if (kind == K_FETCH) exp_addr = 64'(instruction_address) & ~64'h7;
        else                 exp_addr = 64'(data_address) & ~64'h7;
        check({tag, " mem_address"}, 64'(mem_address), exp_addr);
        check({tag, " mem_we"}, 64'(mem_we), 64'(kind == K_STORE));
        if (kind == K_STORE) begin
            off = lane_off(data_address[2:0], sz);
            check({tag, " mem_byte_en"}, 64'(mem_byte_en),
                  64'((((1 << (1 << sz)) - 1) << off) & 8'hFF));
            check({tag, " mem_wdata"}, mem_wdata, output_data << (8 * off));
        end
        for (int i = 0; i < wait_cyc; i++) begin
            mem_rdata = rand64();
            step();
            check({tag, " held_wait"}, {61'd0, mem_req, pulses()}, 64'h8);
        end
        mem_ack   = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ack   = 1'b0;
        mem_rdata = rand64();
        exp_pulse = (kind == K_FETCH) ? 3'b100 : (kind == K_LOAD) ? 3'b010 : 3'b001;
        check({tag, " resp_pulse"}, 64'(pulses()), 64'(exp_pulse));
        check({tag, " req_low_in_resp"}, 64'(mem_req), 64'd0);
        if (kind == K_FETCH) begin
            exp_val = (rdata >> (32 * int'(instruction_address[2]))) & 64'hFFFF_FFFF;
            last_instr_exp = exp_val[31:0];
            check({tag, " instruction"}, 64'(input_instruction), exp_val);
            check({tag, " load_held"}, input_data, last_load_exp);
        end else if (kind == K_LOAD) begin
            exp_val = model_load(rdata, data_address[2:0], sz, input_data_unsigned);
            last_load_exp = exp_val;
            check({tag, " load_data"}, input_data, exp_val);
            check({tag, " instr_held"}, 64'(input_instruction), 64'(last_instr_exp));
        end else begin
            exp_val = 64'd0;
            check({tag, " load_held"}, input_data, last_load_exp);
        end
        $display("xfer %s kind=%0d addr=%h size=%0d wait=%0d value=%h",
                 tag, kind, (kind == K_FETCH) ? instruction_address : data_address,
                 sz, wait_cyc, exp_val);
        if (kind == K_FETCH)     input_instruction_request = 1'b0;
        else if (kind == K_LOAD) input_data_request = 1'b0;
        else                     output_data_request = 1'b0;
        step();
        check({tag, " single_resp"}, 64'(pulses()), 64'd0);
    endtask

    task automatic start_data(input logic [55:0] addr, input logic [1:0] size, input bit uns,
                              input logic [63:0] wd, input bit is_store);
        data_address        = addr;
        data_size           = size;
        input_data_unsigned = uns;
        output_data         = wd;
        if (is_store) output_data_request = 1'b1;
        else          input_data_request  = 1'b1;
    endtask

    initial begin
        int last_grant_model;
        int kind;
        int sz;
        logic [55:0] a;

        instruction_address = '0;
        data_address        = '0;
        data_size           = 2'd0;
        input_data_unsigned = 1'b0;
        output_data         = 64'd0;
        rst                 = 1'b1;
        drop_all();
        mem_ack   = 1'b0;
        mem_rdata = 64'd0;
        step();
        // Reset values while rst is held
        check("rst mem_ctrl", {61'd0, mem_req, mem_we, misaligned}, 64'd0);
        check("rst pulses", 64'(pulses()), 64'd0);
        check("rst mem_address", 64'(mem_address), 64'd0);
        check("rst byte_en", 64'(mem_byte_en), 64'd0);
        check("rst wdata", mem_wdata, 64'd0);
        check("rst input_data", input_data, 64'd0);
        check("rst input_instruction", 64'(input_instruction), 64'd0);
        do_reset();

        // Fetch at 0x104, zero-wait ack
        instruction_address = 56'h104;
        input_instruction_request = 1'b1;
        serve(K_FETCH, 64'h1111_2222_3333_4444, 0, "fetch104");

        // Load byte at 0x7, signed then unsigned
        start_data(56'h7, 2'd0, 1'b0, 64'd0, 1'b0);
        serve(K_LOAD, 64'h8000_0000_0000_0000, 0, "ldb_signed");
        start_data(56'h7, 2'd0, 1'b1, 64'd0, 1'b0);
        serve(K_LOAD, 64'h8000_0000_0000_0000, 1, "ldb_unsigned");

        // Store half 0xBEEF at 0x12
        start_data(56'h12, 2'd1, 1'b0, 64'h0000_0000_0000_BEEF, 1'b1);
        serve(K_STORE, 64'd0, 2, "sth_12");

`ifndef MEM_ARBITER_ALIGN_CHECK_EN
        // Unaligned word load truncates to the containing lane
        start_data(56'h6, 2'd2, 1'b0, 64'd0, 1'b0);
        serve(K_LOAD, 64'h89AB_CDEF_0123_4567, 0, "ldw_trunc");
`endif

        // mem_ack outside ISSUE is ignored
        mem_ack = 1'b1;
        step();
        step();
        mem_ack = 1'b0;
        check("ack_idle ignored", {61'd0, mem_req, pulses()}, 64'd0);

        // Store and load together: store first, then load
        start_data(56'h48, 2'd3, 1'b0, 64'hCAFE_F00D_1234_5678, 1'b1);
        input_data_request = 1'b1;
        serve(K_STORE, 64'd0, 0, "collide_store");
        serve(K_LOAD, 64'h0102_0304_0506_0708, 0, "collide_load");

        // Randomized single-requester transactions
        for (int t = 0; t < 16; t++) begin
            kind = int'($urandom_range(0, 2));
            sz   = int'($urandom_range(0, 3));
            a    = rand64()[55:0];
            if (kind == K_FETCH) begin
                instruction_address = a & ~56'h3;
                input_instruction_request = 1'b1;
            end else begin
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
                a = a & ~56'((1 << sz) - 1);
`endif
                start_data(a, 2'(sz), 1'($urandom_range(0, 1)), rand64(), kind == K_STORE);
            end
            serve(kind, rand64(), int'($urandom_range(0, 3)), $sformatf("rand%0d", t));
        end

        // Round-robin with fetch and load both held, fetch first after reset
        do_reset();
        instruction_address = 56'h2004;
        start_data(56'h3008, 2'd3, 1'b0, 64'd0, 1'b0);
        input_instruction_request = 1'b1;
        last_grant_model = 0;
        for (int t = 0; t < 4; t++) begin
            kind = (last_grant_model == 0) ? K_FETCH : K_LOAD;
            serve(kind, rand64(), t % 2, $sformatf("rr%0d", t));
            last_grant_model = (kind == K_FETCH) ? 1 : 0;
            input_instruction_request = 1'b1;
            input_data_request = 1'b1;
        end
        drop_all();

        // Reset during a held-off ack
        start_data(56'h100, 2'd3, 1'b0, 64'd0, 1'b0);
        step();
        check("midrst req_up", 64'(mem_req), 64'd1);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("midrst req_async_low", 64'(mem_req), 64'd0);
        check("midrst no_pulse", 64'(pulses()), 64'd0);
        drop_all();
        step();
        rst = 1'b0;
        last_load_exp  = 64'd0;
        last_instr_exp = 32'd0;
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        mem_ack = 1'b0;
        step();
        check("midrst idle", {61'd0, mem_req, pulses()}, 64'd0);
        check("midrst data_cleared", input_data, 64'd0);

`ifdef MEM_ARBITER_ALIGN_CHECK_EN
        // Misaligned word load at 0x6 is rejected without a memory access
        start_data(56'h6, 2'd2, 1'b0, 64'd0, 1'b0);
        step();
        check("misal mem_req", 64'(mem_req), 64'd0);
        check("misal flag", 64'(misaligned), 64'd1);
        check("misal pulse", 64'(pulses()), 64'b010);
        check("misal data", input_data, 64'd0);
        drop_all();
        step();
        check("misal flag_clear", {61'd0, misaligned, input_data_valid, mem_req}, 64'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one 64-bit word-wide memory port between the CPU's instruction-fetch port and its data load/store port. It sits between the `cpu` core and the RAM/bus interface. Each granted access runs as a single-outstanding transaction: the block arbitrates, aligns byte lanes, sign-extends reads, and generates byte enables for writes.

## Interface
Parameters:
- `ADDR_W`, 56: physical address width.
- `MEM_RESET_GRANT`, 0: initial `last_grant` value (0 = data, 1 = instruction).

Ports:
- `phi1` in 1: sole clock. The block uses one clock; reset is asynchronous and active-high.
- `rst` in 1: asynchronous, active-high reset.
- `instruction_address` in 56: fetch address, 4-byte aligned.
- `input_instruction_request` in 1: fetch request, held until valid.
- `input_instruction` out 32: fetched instruction.
- `input_instruction_valid` out 1: one-cycle response pulse.
- `data_address` in 56: load/store byte address.
- `data_size` in 2: 0=B, 1=H, 2=W, 3=D.
- `input_data_request` in 1: load request, held until valid.
- `input_data_unsigned` in 1: zero-extend load when high.
- `input_data` out 64: extended load data.
- `input_data_valid` out 1: one-cycle load response pulse.
- `output_data` in 64: store data, right-justified.
- `output_data_request` in 1: store request, held until complete.
- `output_data_complete` out 1: one-cycle store response pulse.
- `misaligned` out 1: one-cycle pulse with a rejected data response.
- `mem_req` out 1: memory transaction active.
- `mem_we` out 1: write when high.
- `mem_address` out 56: byte address with [2:0] forced to 0.
- `mem_byte_en` out 8: write byte lanes.
- `mem_wdata` out 64: lane-shifted write data.
- `mem_rdata` in 64: read word.
- `mem_ack` in 1: transaction done; `mem_rdata` valid in the same cycle.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE: requests are sampled. On any pending request, register the address, size, write data and lane info, then go to ISSUE. Requests are ignored in ISSUE and RESP.
- Priority when several requests are pending:
  - A data store and a data load requested together is a protocol error. The store is served first, then the load as a separate transaction.
  - Data vs fetch: round-robin. Grant the requester that did not receive `last_grant`, then update `last_grant`.
- ISSUE: `mem_req` is high; address and controls are held stable. On `mem_ack`, capture and format `mem_rdata`, then go to RESP.
- RESP: exactly one of `input_instruction_valid`, `input_data_valid` or `output_data_complete` is high for one cycle, then the FSM returns to IDLE. The requester deasserts its request at the edge that ends RESP.
- Read lanes:
  - Instruction = `mem_rdata >> 32*addr[2]`, bits [31:0].
  - Data B/H/W/D is extracted at shift 8*addr[2:0], 16*addr[2:1] and 32*addr[2] respectively (D is the whole word).
  - Result is sign-extended to 64 unless `input_data_unsigned` is high.
- Write lanes: `mem_wdata = output_data << shift`. `mem_byte_en` = 0x01/0x03/0x0F/0xFF shifted by the lane byte offset.
- Outputs hold their last response data between responses.
- Reset values: all outputs are 0, `last_grant` = `MEM_RESET_GRANT`.

## Timing
- Request seen at edge 0 in IDLE. `mem_req` is high from edge 1.
- `mem_ack` sampled at edge k gives valid/complete high during k..k+1, and IDLE at k+1.
- Minimum request-to-valid latency is 2 cycles, with a zero-wait `mem_ack` at edge 2.
- `mem_ack` is ignored outside ISSUE.
- A back-to-back request can be granted at the first IDLE edge after RESP, giving one idle cycle between transactions.
- When `rst` is asserted mid-transaction, the FSM goes to IDLE and `mem_req` falls immediately (asynchronously). The in-flight access is abandoned and no response is produced.
- `mem_ack` may be held off indefinitely. There is no timeout.

## Configuration
- `MEM_ARBITER_ALIGN_CHECK_EN` defined:
  - A data access is misaligned when H has addr[0]≠0, W has addr[1:0]≠0, or D has addr[2:0]≠0.
  - A misaligned access skips ISSUE and goes IDLE→RESP.
  - In that RESP cycle, `misaligned`=1 and the valid/complete pulse is asserted. `input_data` = 0 and no memory write occurs.
- Macro undefined: no check is performed and `misaligned` is tied to 0. Low address bits beyond the lane selection are ignored, so addresses truncate to the containing lane.

## Structure
- `mem_arbiter_pkg`:
  - `arb_state_t` enum for the FSM states.
  - `mem_size_t` enum with `SIZE_B`, `SIZE_H`, `SIZE_W`, `SIZE_D`.
  - Constant `ADDR_W`.
  - Lane mask constants.
- Sub-module `mem_lane_align`: purely combinational. Handles read extract and sign extension, plus write shift and byte-enable generation. Instantiated once, driven by the registered request fields.

## Test plan
- Fetch at 0x104 with `mem_rdata`=0x1111_2222_3333_4444 and zero-wait ack: expect `mem_address`=0x100, then `input_instruction`=0x11112222 after 2 cycles.
- Load B at 0x7, signed, with `mem_rdata`=0x8000_0000_0000_0000: expect `input_data`=0xFFFF_FFFF_FFFF_FF80. Repeat unsigned: expect 0x80.
- Store H of 0xBEEF at 0x12: expect `mem_byte_en`=0x0C, `mem_wdata`[31:16]=0xBEEF, `mem_we`=1, then `output_data_complete` pulse.
- Fetch and load held together for 4 transactions: expect grants to alternate, fetch first after reset, with exactly one response per transaction.
- `mem_ack` delayed 5 cycles, with `rst` asserted in the 3rd: expect `mem_req`=0 immediately, no valid pulse, FSM in IDLE.
- With `MEM_ARBITER_ALIGN_CHECK_EN`, load W at 0x6: expect no `mem_req`, and `misaligned`=1 with `input_data_valid`=1 and `input_data`=0 one cycle after the request.
